mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundle of every handshake and memory-bus signal around mem_port_arbiter.
//   Signals:
//     i_req, i_addr       -> fetch request and its address (relative to IMEM_BASE)
//     i_ack, i_rdata      <- fetch completion and the fetched word
//     d_req, d_we, d_func3, d_addr, d_wdata
//                         -> load/store request
//     d_ack, d_rdata      <- data completion and the load result
//     mem_read, mem_write, mem_func3, mem_addr, mem_wdata
//                         <- drive to the single-ported memory
//     mem_rdata           -> combinational read data from the memory
//   Modports:
//     slave  : the arbiter side (consumes requests, drives memory pins)
//     master : the environment side (requesters plus memory)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_func3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_func3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, byte-addressed unified memory between the
//   instruction-fetch requester (I) and the load/store requester (D).
//   One access is granted per cycle and drives the memory pins in that same
//   cycle; the winner sees a one-cycle ack in the next cycle together with the
//   registered read data. Data accesses win, except that after MAX_D_STREAK
//   consecutive data grants with a fetch waiting, the fetch is served.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset; also forces mem_* to 0
//     bus          mem_port_arbiter_if.slave (requests, acks, memory pins)
//     if_stall_cnt (only with ARB_PERF_EN) cycles with i_req high that were
//                  not granted to the fetch port, wrapping modulo 2^32
//
//   Optional feature macro: ARB_PERF_EN (adds if_stall_cnt and its counter).
module mem_port_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int IMEM_BASE    = 256,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]         if_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    localparam int                STREAK_W   = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [ADDR_W-1:0] IMEM_OFS   = ADDR_W'(IMEM_BASE);
    localparam logic [2:0]        F3_LW      = 3'b010;

    // grant_d is the grant of the current cycle; grant_q remembers it so the
    // ack can be raised in the following cycle.
    grant_t                grant_d,   grant_q;
    logic [STREAK_W-1:0]   streak_d,  streak_q;
    logic [31:0]           i_rdata_d, i_rdata_q;
    logic [31:0]           d_rdata_d, d_rdata_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant_d = GNT_NONE;
        if (bus.d_req && !(bus.i_req && (streak_q == STREAK_MAX))) begin
            grant_d = GNT_D;
        end else if (bus.i_req) begin
            grant_d = GNT_I;
        end
    end

    // Streak only measures data grants while a fetch is actually waiting.
    always_comb begin
        streak_d = streak_q;
        if (!bus.i_req || (grant_d == GNT_I)) begin
            streak_d = '0;
        end else if ((grant_d == GNT_D) && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Memory pin drive (combinational, in the grant cycle)
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_func3 = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        // Reset blanks the pins so a store granted during reset is not written.
        if (!rst) begin
            unique case (grant_d)
                GNT_D: begin
                    bus.mem_read  = ~bus.d_we;
                    bus.mem_write = bus.d_we;
                    bus.mem_func3 = bus.d_func3;
                    bus.mem_addr  = bus.d_addr;
                    bus.mem_wdata = bus.d_wdata;
                end
                GNT_I: begin
                    bus.mem_read  = 1'b1;
                    bus.mem_func3 = F3_LW;
                    // Fetch addresses wrap inside the ADDR_W address space.
                    bus.mem_addr  = IMEM_OFS + bus.i_addr;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-data capture
    // ------------------------------------------------------------------
    always_comb begin
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (grant_d == GNT_I) begin
            i_rdata_d = bus.mem_rdata;
        end
        // Stores leave the previous load result in place.
        if ((grant_d == GNT_D) && !bus.d_we) begin
            d_rdata_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= GNT_NONE;
            streak_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            grant_q   <= grant_d;
            streak_q  <= streak_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.i_ack   = (grant_q == GNT_I);
    assign bus.d_ack   = (grant_q == GNT_D);
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

`ifdef ARB_PERF_EN
    // ------------------------------------------------------------------
    // Fetch stall counter
    // ------------------------------------------------------------------
    logic [31:0] stall_d, stall_q;

    always_comb begin
        stall_d = stall_q;
        if (bus.i_req && (grant_d != GNT_I)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign if_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: a byte-array memory model with
//   combinational reads, a directed vector table, hand-written streak and
//   reset-during-store sequences, and randomized traffic checked against a
//   behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 11;
    localparam int MEMSZ  = 2048;
    localparam int IBASE  = 256;
    localparam int MAXS   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef ARB_PERF_EN
    logic [31:0] if_stall_cnt;
`endif

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .IMEM_BASE   (IBASE),
        .MAX_D_STREAK(MAXS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_PERF_EN
        ,
        .if_stall_cnt(if_stall_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Memory model
    // ------------------------------------------------------------------
    logic [7:0] mem [0:MEMSZ-1];
    logic       preload = 1'b0;
    logic       wr_tick = 1'b0;

    function automatic logic [31:0] ref_read(input logic [10:0] a, input logic [2:0] f3);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a];
        b1 = mem[a + 11'd1];
        b2 = mem[a + 11'd2];
        b3 = mem[a + 11'd3];
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < MEMSZ; k++) mem[k] <= 8'h00;
            mem[0]   <= 8'd17;
            mem[4]   <= 8'd9;
            mem[8]   <= 8'd25;
            mem[20]  <= 8'h80;
            mem[256] <= 8'h0D; mem[257] <= 8'hF0; mem[258] <= 8'hFE; mem[259] <= 8'hCA;
            mem[264] <= 8'h78; mem[265] <= 8'h56; mem[266] <= 8'h34; mem[267] <= 8'h12;
            wr_tick  <= ~wr_tick;
        end else if (bus.mem_write) begin
            case (bus.mem_func3)
                3'b000: mem[bus.mem_addr] <= bus.mem_wdata[7:0];
                3'b001: begin
                    mem[bus.mem_addr]         <= bus.mem_wdata[7:0];
                    mem[bus.mem_addr + 11'd1] <= bus.mem_wdata[15:8];
                end
                3'b010: begin
                    mem[bus.mem_addr]         <= bus.mem_wdata[7:0];
                    mem[bus.mem_addr + 11'd1] <= bus.mem_wdata[15:8];
                    mem[bus.mem_addr + 11'd2] <= bus.mem_wdata[23:16];
                    mem[bus.mem_addr + 11'd3] <= bus.mem_wdata[31:24];
                end
                default: ;
            endcase
            wr_tick <= ~wr_tick;
        end
    end

    always @(bus.mem_addr, bus.mem_func3, wr_tick) begin
        bus.mem_rdata = ref_read(bus.mem_addr, bus.mem_func3);
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_mem(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [10:0] a, input logic [31:0] wd);
        chk({tag, ".mem_read"},  32'(bus.mem_read),  32'(rd));
        chk({tag, ".mem_write"}, 32'(bus.mem_write), 32'(wr));
        chk({tag, ".mem_func3"}, 32'(bus.mem_func3), 32'(f3));
        chk({tag, ".mem_addr"},  32'(bus.mem_addr),  32'(a));
        chk({tag, ".mem_wdata"}, bus.mem_wdata,      wd);
    endtask

    task automatic drive(input logic ireq, input logic [10:0] iaddr, input logic dreq,
                         input logic dwe, input logic [2:0] df3, input logic [10:0] daddr,
                         input logic [31:0] dwdata);
        bus.i_req   = ireq;
        bus.i_addr  = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_func3 = df3;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: state of the arbitration rules
    // ------------------------------------------------------------------
    int          m_streak;
    int unsigned m_stall;
    logic [31:0] m_irdata;
    logic [31:0] m_drdata;

    // One cycle of traffic: g = 0 none, 1 fetch, 2 data.
    task automatic model_step(input string tag, input logic ireq, input logic [10:0] iaddr,
                              input logic dreq, input logic dwe, input logic [2:0] df3,
                              input logic [10:0] daddr, input logic [31:0] dwdata,
                              output int g, output logic [10:0] seen_addr);
        logic [10:0] fa;
        fa = 11'((IBASE + int'(iaddr)) % MEMSZ);
        drive(ireq, iaddr, dreq, dwe, df3, daddr, dwdata);
        @(negedge clk);
        if (dreq && !(ireq && m_streak == MAXS)) g = 2;
        else if (ireq)                           g = 1;
        else                                     g = 0;
        seen_addr = bus.mem_addr;
        if (g == 2)      chk_mem(tag, ~dwe, dwe, df3, daddr, dwdata);
        else if (g == 1) chk_mem(tag, 1'b1, 1'b0, 3'b010, fa, 32'h0);
        else             chk_mem(tag, 1'b0, 1'b0, 3'b000, 11'h0, 32'h0);
        if (g == 1)             m_irdata = ref_read(fa, 3'b010);
        if (g == 2 && !dwe)     m_drdata = ref_read(daddr, df3);
        if (!ireq || g == 1)    m_streak = 0;
        else if (g == 2)        m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
        if (ireq && g != 1)     m_stall++;
        @(posedge clk);
        #1;
        chk({tag, ".i_ack"},   32'(bus.i_ack), (g == 1) ? 32'd1 : 32'd0);
        chk({tag, ".d_ack"},   32'(bus.d_ack), (g == 2) ? 32'd1 : 32'd0);
        chk({tag, ".i_rdata"}, bus.i_rdata, m_irdata);
        chk({tag, ".d_rdata"}, bus.d_rdata, m_drdata);
`ifdef ARB_PERF_EN
        chk({tag, ".if_stall_cnt"}, if_stall_cnt, m_stall);
`endif
    endtask

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic        ireq;
        logic [10:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [2:0]  df3;
        logic [10:0] daddr;
        logic [31:0] dwdata;
        logic        e_rd;
        logic        e_wr;
        logic [2:0]  e_f3;
        logic [10:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_iack;
        logic        e_dack;
        logic [31:0] e_irdata;
        logic [31:0] e_drdata;
    } vec_t;

    function automatic vec_t mk(input logic ireq, input logic [10:0] iaddr, input logic dreq,
                                input logic dwe, input logic [2:0] df3, input logic [10:0] daddr,
                                input logic [31:0] dwdata, input logic e_rd, input logic e_wr,
                                input logic [2:0] e_f3, input logic [10:0] e_addr,
                                input logic [31:0] e_wdata, input logic e_iack, input logic e_dack,
                                input logic [31:0] e_irdata, input logic [31:0] e_drdata);
        vec_t v;
        v.ireq = ireq;   v.iaddr = iaddr;   v.dreq = dreq;     v.dwe = dwe;
        v.df3 = df3;     v.daddr = daddr;   v.dwdata = dwdata;
        v.e_rd = e_rd;   v.e_wr = e_wr;     v.e_f3 = e_f3;     v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_iack = e_iack; v.e_dack = e_dack;
        v.e_irdata = e_irdata; v.e_drdata = e_drdata;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        int          g;
        logic [10:0] sa;
        int          pat [10];
        int          obs;

        //            ireq iaddr   dreq we f3     daddr   wdata          rd wr f3     addr    wdata          ia da irdata         drdata
        vecs[0]  = mk(0, 11'd0,    0, 0, 3'd0, 11'd0,  32'h0,         0, 0, 3'd0, 11'd0,  32'h0,         0, 0, 32'h0,         32'h0);
        vecs[1]  = mk(0, 11'd0,    1, 0, 3'd2, 11'd4,  32'h11112222,  1, 0, 3'd2, 11'd4,  32'h11112222,  0, 1, 32'h0,         32'd9);
        vecs[2]  = mk(1, 11'd8,    0, 0, 3'd0, 11'd0,  32'h0,         1, 0, 3'd2, 11'd264,32'h0,         1, 0, 32'h12345678,  32'd9);
        vecs[3]  = mk(1, 11'd0,    1, 0, 3'd2, 11'd8,  32'h0,         1, 0, 3'd2, 11'd8,  32'h0,         0, 1, 32'h12345678,  32'd25);
        vecs[4]  = mk(1, 11'd0,    0, 0, 3'd0, 11'd0,  32'h0,         1, 0, 3'd2, 11'd256,32'h0,         1, 0, 32'hCAFEF00D,  32'd25);
        vecs[5]  = mk(0, 11'd0,    1, 1, 3'd0, 11'd12, 32'h000000AB,  0, 1, 3'd0, 11'd12, 32'h000000AB,  0, 1, 32'hCAFEF00D,  32'd25);
        vecs[6]  = mk(0, 11'd0,    1, 0, 3'd4, 11'd12, 32'h0,         1, 0, 3'd4, 11'd12, 32'h0,         0, 1, 32'hCAFEF00D,  32'h000000AB);
        vecs[7]  = mk(0, 11'd0,    1, 0, 3'd0, 11'd20, 32'h0,         1, 0, 3'd0, 11'd20, 32'h0,         0, 1, 32'hCAFEF00D,  32'hFFFFFF80);
        vecs[8]  = mk(1, 11'd1800, 0, 0, 3'd0, 11'd0,  32'h0,         1, 0, 3'd2, 11'd8,  32'h0,         1, 0, 32'd25,        32'hFFFFFF80);
        vecs[9]  = mk(0, 11'd0,    1, 1, 3'd2, 11'd16, 32'h55AA55AA,  0, 1, 3'd2, 11'd16, 32'h55AA55AA,  0, 1, 32'd25,        32'hFFFFFF80);
        vecs[10] = mk(0, 11'd0,    1, 0, 3'd2, 11'd16, 32'h0,         1, 0, 3'd2, 11'd16, 32'h0,         0, 1, 32'd25,        32'h55AA55AA);
        vecs[11] = mk(0, 11'd0,    1, 0, 3'd1, 11'd20, 32'h0,         1, 0, 3'd1, 11'd20, 32'h0,         0, 1, 32'd25,        32'h00000080);
        vecs[12] = mk(0, 11'd0,    1, 1, 3'd1, 11'd22, 32'h00008001,  0, 1, 3'd1, 11'd22, 32'h00008001,  0, 1, 32'd25,        32'h00000080);
        vecs[13] = mk(0, 11'd0,    1, 0, 3'd1, 11'd22, 32'h0,         1, 0, 3'd1, 11'd22, 32'h0,         0, 1, 32'd25,        32'hFFFF8001);
        vecs[14] = mk(0, 11'd0,    0, 0, 3'd0, 11'd0,  32'h0,         0, 0, 3'd0, 11'd0,  32'h0,         0, 0, 32'd25,        32'hFFFF8001);

        // ---------------- reset state ----------------
        drive(0, 11'd0, 1, 1, 3'd2, 11'd40, 32'hDEADBEEF);
        preload = 1'b1;
        @(posedge clk);
        #1;
        preload = 1'b0;
        @(negedge clk);
        chk_mem("reset", 1'b0, 1'b0, 3'd0, 11'd0, 32'h0);
        chk("reset.i_ack",   32'(bus.i_ack), 32'd0);
        chk("reset.d_ack",   32'(bus.d_ack), 32'd0);
        chk("reset.i_rdata", bus.i_rdata,    32'd0);
        chk("reset.d_rdata", bus.d_rdata,    32'd0);
        @(posedge clk);
        #1;
        chk("reset.store_blocked", ref_read(11'd40, 3'd2), 32'd0);
        drive(0, 11'd0, 0, 0, 3'd0, 11'd0, 32'h0);
        rst = 1'b0;

        // ---------------- directed table ----------------
        for (int unsigned i = 0; i < 15; i++) begin
            drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
                  vecs[i].df3, vecs[i].daddr, vecs[i].dwdata);
            @(negedge clk);
            chk_mem($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_wr,
                    vecs[i].e_f3, vecs[i].e_addr, vecs[i].e_wdata);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.i_ack", i),   32'(bus.i_ack), 32'(vecs[i].e_iack));
            chk($sformatf("vec%0d.d_ack", i),   32'(bus.d_ack), 32'(vecs[i].e_dack));
            chk($sformatf("vec%0d.i_rdata", i), bus.i_rdata,    vecs[i].e_irdata);
            chk($sformatf("vec%0d.d_rdata", i), bus.d_rdata,    vecs[i].e_drdata);
        end

        // ---------------- reset during a granted store ----------------
        drive(0, 11'd0, 1, 1, 3'd2, 11'd0, 32'hFFFFFFFF);
        @(negedge clk);
        chk("rststore.granted_write", 32'(bus.mem_write), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rststore.mem_write_forced", 32'(bus.mem_write), 32'd0);
        chk("rststore.mem_addr_forced",  32'(bus.mem_addr),  32'd0);
        @(posedge clk);
        #1;
        chk("rststore.no_d_ack", 32'(bus.d_ack), 32'd0);
        chk("rststore.d_rdata",  bus.d_rdata,    32'd0);
        rst = 1'b0;
        m_streak = 0;
        m_stall  = 0;
        m_irdata = 32'h0;
        m_drdata = 32'h0;
        model_step("rststore.lw0", 0, 11'd0, 1, 0, 3'd2, 11'd0, 32'h0, g, sa);
        chk("rststore.lw0_value", bus.d_rdata, 32'd17);

        // ---------------- streak limiter ----------------
        pat = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        for (int k = 0; k < 10; k++) begin
            model_step($sformatf("streak%0d", k), 1, 11'd4, 1, 0, 3'd2, 11'd0, 32'h0, g, sa);
            obs = (sa == 11'd260) ? 1 : ((sa == 11'd0) ? 2 : 0);
            chk($sformatf("streak%0d.grant", k), 32'(obs), 32'(pat[k]));
`ifdef ARB_PERF_EN
            if (k == 4) chk("streak.stall_at_i_grant", if_stall_cnt, 32'd4);
`endif
        end

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 400; n++) begin
            logic        ir, dr, we;
            logic [2:0]  f3;
            logic [10:0] ia, da;
            logic [31:0] wd;
            int          sel;
            ir  = ($urandom_range(0, 2) != 0);
            dr  = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 4);
            if (we) f3 = 3'(sel % 3);
            else    f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
            ia  = 11'($urandom_range(0, MEMSZ - 1));
            da  = 11'($urandom_range(0, MEMSZ - 1));
            wd  = $urandom;
            model_step($sformatf("rnd%0d", n), ir, ia, dr, we, f3, da, wd, g, sa);
        end

        drive(0, 11'd0, 0, 0, 3'd0, 11'd0, 32'h0);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
